// File: rtl/fx_div_seq.sv
// Sequential signed Q4.12 divider: unsigned restoring division on magnitudes, one
// quotient bit per clock, followed by sign, saturation and divide-by-zero handling.
module fx_div_seq #(
    parameter int FRAC = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] q,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic        dbz
);
    localparam int DW = 16 + FRAC;
    localparam int CW = $clog2(DW);
    localparam logic [DW-1:0] POS_LIM = DW'(32'h7FFF);
    localparam logic [DW-1:0] NEG_LIM = DW'(32'h8000);

    typedef enum logic [1:0] {IDLE, DIV, FIN} state_t;
    state_t r_state, w_next;

    logic [DW-1:0] r_dvd;
    logic [16:0]   r_rem;
    logic [15:0]   r_b;
    logic [15:0]   r_q;
    logic [CW-1:0] r_cnt;
    logic          r_neg, r_aneg, r_bz, r_done, r_ovf, r_dbz;

    logic [15:0]   w_absa, w_absb;
    logic [17:0]   w_trial;
    logic          w_fit;
    logic [15:0]   w_q;
    logic          w_ovf;

    // 0x8000 negates to itself, which reads correctly as the unsigned magnitude 32768.
    assign w_absa  = a[15] ? (~a + 16'd1) : a;
    assign w_absb  = b[15] ? (~b + 16'd1) : b;
    assign w_trial = {r_rem, r_dvd[DW-1]};
    assign w_fit   = (w_trial >= {2'b00, r_b});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (start) w_next = (b == 16'd0) ? FIN : DIV;
            DIV:  if (r_cnt == CW'(DW - 1)) w_next = FIN;
            FIN:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Quotient magnitude occupies r_dvd after the last iteration.
    always_comb begin
        w_q   = '0;
        w_ovf = 1'b0;
        if (r_bz) begin
            w_q = r_aneg ? 16'h8000 : 16'h7FFF;
        end else if (r_neg) begin
            if (r_dvd > NEG_LIM) begin
                w_q   = 16'h8000;
                w_ovf = 1'b1;
            end else begin
                w_q = ~r_dvd[15:0] + 16'd1;
            end
        end else if (r_dvd > POS_LIM) begin
            w_q   = 16'h7FFF;
            w_ovf = 1'b1;
        end else begin
            w_q = r_dvd[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dvd  <= '0;
            r_rem  <= '0;
            r_b    <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_neg  <= 1'b0;
            r_aneg <= 1'b0;
            r_bz   <= 1'b0;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
            r_dbz  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_dvd  <= {w_absa, {FRAC{1'b0}}};
                        r_b    <= w_absb;
                        r_rem  <= '0;
                        r_cnt  <= '0;
                        r_neg  <= a[15] ^ b[15];
                        r_aneg <= a[15];
                        r_bz   <= (b == 16'd0);
                        r_ovf  <= 1'b0;
                        r_dbz  <= 1'b0;
                    end
                end
                DIV: begin
                    r_rem <= w_fit ? 17'(w_trial - {2'b00, r_b}) : w_trial[16:0];
                    r_dvd <= {r_dvd[DW-2:0], w_fit};
                    r_cnt <= r_cnt + 1'b1;
                end
                FIN: begin
                    r_q    <= w_q;
                    r_ovf  <= w_ovf;
                    r_dbz  <= r_bz;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign q    = r_q;
    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign ovf  = r_ovf;
    assign dbz  = r_dbz;

endmodule
